// File: rtl/decap_pkg.sv
// decap_pkg: shared command, select, result-count and state encodings for the decapsulation host controller
package decap_pkg;
  localparam logic [1:0] CMD_IDLE = 2'd0, CMD_INIT = 2'd1, CMD_RUN = 2'd3;
  localparam logic [1:0] SEL_C = 2'd0, SEL_SK = 2'd1, SEL_K = 2'd2, SEL_RHO = 2'd3;
  localparam int NUM_OUT = 8;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_RUN, S_READ, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/decap_load_demux.sv
// decap_load_demux: per-memory address counters, overflow drop and registered write demux
module decap_load_demux
  import decap_pkg::*;
#(
  parameter int P_WIDTH_K = 8,
  parameter int Q_DEPTH_K = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       acc,
  input  logic [1:0]                 sel,
  input  logic [P_WIDTH_K-1:0]       data,
  output logic [3:0]                 wr_en,
  output logic [3:0][Q_DEPTH_K-1:0]  wr_addr,
  output logic [3:0][P_WIDTH_K-1:0]  wr_di,
  output logic                       drop
);
  logic [3:0][Q_DEPTH_K-1:0] cnt;
  logic [3:0]                full;
  assign drop = acc & full[sel];
  always_ff @(posedge clk)
    if (rst) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_di   <= '0;
      cnt     <= '0;
      full    <= '0;
    end else begin
      wr_en <= '0;
      if (clr) begin
        cnt  <= '0;
        full <= '0;
      end else if (acc && !full[sel]) begin
        wr_en[sel]   <= 1'b1;
        wr_addr[sel] <= cnt[sel];
        wr_di[sel]   <= data;
        if (&cnt[sel]) full[sel] <= 1'b1;
        else cnt[sel] <= cnt[sel] + 1'b1;
      end
    end
endmodule

// File: rtl/decap_host_ctrl.sv
// decap_host_ctrl: sequences init, load, run with timeout and result readout for the decapsulation core
module decap_host_ctrl
  import decap_pkg::*;
#(
  parameter int P_WIDTH_K   = 8,
  parameter int Q_DEPTH_K   = 11,
  parameter int INIT_CYCLES = 5,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_W   = 24
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [P_WIDTH_K-1:0] in_data,
  input  logic                 in_last,
  output logic [1:0]           Cmd,
  output logic                 wr_en_C,
  output logic                 wr_en_sk,
  output logic                 wr_en_k,
  output logic                 wr_en_rho,
  output logic [Q_DEPTH_K-1:0] wr_addr_C,
  output logic [Q_DEPTH_K-1:0] wr_addr_sk,
  output logic [Q_DEPTH_K-1:0] wr_addr_k,
  output logic [Q_DEPTH_K-1:0] wr_addr_rho,
  output logic [P_WIDTH_K-1:0] wr_di_C,
  output logic [P_WIDTH_K-1:0] wr_di_sk,
  output logic [P_WIDTH_K-1:0] wr_di_k,
  output logic [P_WIDTH_K-1:0] wr_di_rho,
  input  logic                 core_valid,
  output logic [2:0]           out_addr,
  input  logic [31:0]          out_r,
  input  logic [31:0]          out_k,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [63:0]          res_data,
  output logic [2:0]           res_idx,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err
);
  localparam logic [TIMEOUT_W-1:0] INIT_END = TIMEOUT_W'(INIT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] RD_END   = TIMEOUT_W'(RD_LAT);
  localparam logic [TIMEOUT_W-1:0] TO_END   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  state_t                    state;
  logic [TIMEOUT_W-1:0]      cnt;
  logic                      fin;
  logic                      go;
  logic                      acc;
  logic                      drop;
  logic [3:0]                wr_en;
  logic [3:0][Q_DEPTH_K-1:0] wr_addr;
  logic [3:0][P_WIDTH_K-1:0] wr_di;
  assign go  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign acc = in_valid && in_ready;
  decap_load_demux #(.P_WIDTH_K(P_WIDTH_K), .Q_DEPTH_K(Q_DEPTH_K)) u_demux (
    .clk(Clk), .rst(Reset), .clr(go), .acc(acc), .sel(in_sel), .data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_di(wr_di), .drop(drop)
  );
  assign {wr_en_rho, wr_en_k, wr_en_sk, wr_en_C} = wr_en;
  assign wr_addr_C   = wr_addr[SEL_C];
  assign wr_addr_sk  = wr_addr[SEL_SK];
  assign wr_addr_k   = wr_addr[SEL_K];
  assign wr_addr_rho = wr_addr[SEL_RHO];
  assign wr_di_C     = wr_di[SEL_C];
  assign wr_di_sk    = wr_di[SEL_SK];
  assign wr_di_k     = wr_di[SEL_K];
  assign wr_di_rho   = wr_di[SEL_RHO];
  always_ff @(posedge Clk)
    if (Reset) begin
      state     <= S_IDLE;
      Cmd       <= CMD_IDLE;
      in_ready  <= 1'b0;
      out_addr  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= '0;
      cnt       <= '0;
      fin       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (drop) err[1] <= 1'b1;
      if (go) begin
        state <= S_INIT;
        Cmd   <= CMD_INIT;
        cnt   <= '0;
        err   <= '0;
        busy  <= 1'b1;
        fin   <= 1'b0;
      end else begin
        case (state)
          S_INIT:
            if (Cmd == CMD_INIT) begin
              if (cnt == INIT_END) Cmd <= CMD_IDLE;
              else cnt <= cnt + 1'b1;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          S_LOAD:
            if (fin) begin
              state <= S_RUN;
              Cmd   <= CMD_RUN;
              cnt   <= '0;
            end else if (acc && in_last) begin
              in_ready <= 1'b0;
              fin      <= 1'b1;
            end
          S_RUN:
            if (core_valid) begin
              Cmd      <= CMD_IDLE;
              state    <= S_READ;
              out_addr <= '0;
              cnt      <= '0;
            end else if (cnt == TO_END) begin
              err[0] <= 1'b1;
              Cmd    <= CMD_IDLE;
              state  <= S_ERR;
              busy   <= 1'b0;
            end else cnt <= cnt + 1'b1;
          S_READ:
            if (!res_valid) begin
              if (cnt == RD_END) begin
                res_data  <= {out_r, out_k};
                res_idx   <= out_addr;
                res_valid <= 1'b1;
              end else cnt <= cnt + 1'b1;
            end else if (res_ready) begin
              res_valid <= 1'b0;
              if (out_addr == 3'(NUM_OUT - 1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                out_addr <= out_addr + 3'd1;
                cnt      <= '0;
              end
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_decap_host_ctrl.sv
// tb_decap_host_ctrl: scoreboard bench for load writes, run timing, timeout, overflow, reset and readout
module tb_decap_host_ctrl;
  logic        clk = 1'b0;
  logic        Reset, start, in_valid, in_ready, in_last, core_valid, res_valid, res_ready, busy, done;
  logic [1:0]  in_sel, Cmd, err;
  logic [7:0]  in_data, wr_di_C, wr_di_sk, wr_di_k, wr_di_rho;
  logic [10:0] wr_addr_C, wr_addr_sk, wr_addr_k, wr_addr_rho;
  logic        wr_en_C, wr_en_sk, wr_en_k, wr_en_rho;
  logic [2:0]  out_addr, res_idx;
  logic [31:0] out_r, out_k;
  logic [63:0] res_data;
  int          n_chk = 0, n_fail = 0;
  int          seed, vdelay, run_cyc, run_len, ini, init_len, done_cnt, beats, stall_left, stalls, drops;
  logic [2:0]  stall_idx, core_a;
  int          n_wr [4];
  logic [10:0] cnt_m [4];
  logic [3:0]  full_m;
  logic [20:0] wr_q [$];
  logic [66:0] res_q [$];
  always #5 clk = ~clk;
  decap_host_ctrl #(.TIMEOUT_W(6)) dut (
    .Clk(clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .in_last(in_last), .Cmd(Cmd),
    .wr_en_C(wr_en_C), .wr_en_sk(wr_en_sk), .wr_en_k(wr_en_k), .wr_en_rho(wr_en_rho),
    .wr_addr_C(wr_addr_C), .wr_addr_sk(wr_addr_sk), .wr_addr_k(wr_addr_k), .wr_addr_rho(wr_addr_rho),
    .wr_di_C(wr_di_C), .wr_di_sk(wr_di_sk), .wr_di_k(wr_di_k), .wr_di_rho(wr_di_rho),
    .core_valid(core_valid), .out_addr(out_addr), .out_r(out_r), .out_k(out_k),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] word(input int sd, input logic [2:0] i);
    logic [31:0] r;
    r = 32'h9E37_79B9 * 32'(sd + 1) + {29'd0, i} * 32'h0101_0101;
    return {r, r ^ 32'hFFFF_0000 ^ {29'd0, i}};
  endfunction
  initial begin
    out_r = '0;
    out_k = '0;
    forever begin
      @(negedge clk);
      core_a = out_addr;
      @(posedge clk);
      #1;
      {out_r, out_k} = word(seed, core_a);
    end
  end
  initial begin
    core_valid = 1'b0;
    run_cyc = 0;
    ini = 0;
    forever begin
      @(negedge clk);
      if (Cmd == 2'd1) ini++;
      else if (ini > 0) begin
        init_len = ini;
        ini = 0;
      end
      if (Cmd == 2'd3) begin
        run_cyc++;
        if (vdelay >= 0 && run_cyc >= vdelay && !core_valid) begin
          core_valid = 1'b1;
          for (int i = 0; i < 8; i++) res_q.push_back({3'(i), word(seed, 3'(i))});
        end
      end else begin
        if (run_cyc > 0) run_len = run_cyc;
        run_cyc = 0;
        core_valid = 1'b0;
      end
    end
  end
  initial begin
    res_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (res_valid && res_idx == stall_idx && stall_left > 0) begin
        chk("hold_data", res_data, word(seed, stall_idx));
        chk("hold_idx", {61'd0, res_idx}, {61'd0, stall_idx});
        chk("hold_addr", {61'd0, out_addr}, {61'd0, stall_idx});
        res_ready = 1'b0;
        stall_left--;
        stalls++;
      end else res_ready = 1'b1;
    end
  end
  initial forever begin
    logic [3:0]  wen;
    logic [10:0] wa [4];
    logic [7:0]  wd [4];
    logic [20:0] e;
    @(negedge clk);
    #2;
    wen = {wr_en_rho, wr_en_k, wr_en_sk, wr_en_C};
    wa = '{wr_addr_C, wr_addr_sk, wr_addr_k, wr_addr_rho};
    wd = '{wr_di_C, wr_di_sk, wr_di_k, wr_di_rho};
    if (wen != 4'd0) chk("wr_onehot", 64'($countones(wen)), 64'd1);
    for (int k = 0; k < 4; k++)
      if (wen[k]) begin
        n_wr[k]++;
        chk("wr_expected", 64'(wr_q.size() > 0), 64'd1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("wr_write", {43'd0, 2'(k), wa[k], wd[k]}, {43'd0, e});
        end
      end
    if (res_valid && res_ready) begin
      beats++;
      chk("res_expected", 64'(res_q.size() > 0), 64'd1);
      if (res_q.size() > 0) begin
        logic [66:0] r;
        r = res_q.pop_front();
        chk("res_data", res_data, r[63:0]);
        chk("res_idx", {61'd0, res_idx}, {61'd0, r[66:64]});
      end
    end
    if (done) done_cnt++;
  end
  task automatic rst_vals(input string tag);
    chk({tag, "_ctl"}, {43'd0, Cmd, wr_en_C, wr_en_sk, wr_en_k, wr_en_rho, in_ready, res_valid, busy, done, err, out_addr, res_idx}, 64'd0);
    chk({tag, "_addr"}, {20'd0, wr_addr_C, wr_addr_sk, wr_addr_k, wr_addr_rho}, 64'd0);
    chk({tag, "_di"}, {32'd0, wr_di_C, wr_di_sk, wr_di_k, wr_di_rho}, 64'd0);
    chk({tag, "_data"}, res_data, 64'd0);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic do_start();
    for (int k = 0; k < 4; k++) begin
      n_wr[k] = 0;
      cnt_m[k] = '0;
    end
    full_m = '0;
    done_cnt = 0;
    beats = 0;
    drops = 0;
    init_len = 0;
    run_len = 0;
    pulse_start();
    chk("start_err_clr", {62'd0, err}, 64'd0);
    chk("start_busy", {63'd0, busy}, 64'd1);
  endtask
  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_sel = s;
    in_data = d;
    in_last = l;
    while (!in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) begin
      if (full_m[s]) drops++;
      else begin
        wr_q.push_back({s, cnt_m[s], d});
        if (cnt_m[s] == 11'h7FF) full_m[s] = 1'b1;
        else cnt_m[s]++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_done(input int budget, input string tag);
    int t = 0;
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    @(negedge clk);
  endtask
  task automatic end_checks(input string tag, input logic [1:0] exp_err);
    chk({tag, "_init_len"}, 64'(init_len), 64'd5);
    chk({tag, "_beats"}, 64'(beats), 64'd8);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    chk({tag, "_res_left"}, 64'(res_q.size()), 64'd0);
    chk({tag, "_err"}, {62'd0, err}, {62'd0, exp_err});
    chk({tag, "_idle"}, {61'd0, busy, Cmd}, 64'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    Reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_sel = '0;
    in_data = '0;
    in_last = 1'b0;
    seed = 0;
    vdelay = 50;
    stall_left = 0;
    stall_idx = 3'd0;
    stalls = 0;
    repeat (3) @(negedge clk);
    rst_vals("rst");
    Reset = 1'b0;
    @(negedge clk);
    seed = 1;
    vdelay = 50;
    do_start();
    for (int i = 0; i < 16; i++) send(2'(i % 4), 8'(8'h10 + i), i == 15);
    wait_done(400, "t1");
    end_checks("t1", 2'b00);
    chk("t1_run_len", 64'(run_len), 64'd50);
    chk("t1_c_writes", 64'(n_wr[0]), 64'd4);
    seed = 2;
    vdelay = 30;
    stall_idx = 3'd3;
    stall_left = 10;
    stalls = 0;
    do_start();
    for (int i = 0; i < 16; i++) send(2'(i % 4), 8'(8'hA0 ^ i), i == 15);
    wait_done(400, "t2");
    end_checks("t2", 2'b00);
    chk("t2_stalls", 64'(stalls), 64'd10);
    seed = 3;
    vdelay = -1;
    do_start();
    for (int i = 0; i < 4; i++) send(2'(i), 8'(8'h30 + i), i == 3);
    t = 0;
    while (err == 2'b00 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("t3_err", {62'd0, err}, 64'd1);
    chk("t3_cmd_busy", {61'd0, busy, Cmd}, 64'd0);
    @(negedge clk);
    chk("t3_run_len", 64'(run_len), 64'd63);
    chk("t3_no_done", 64'(done_cnt), 64'd0);
    chk("t3_init_len", 64'(init_len), 64'd5);
    seed = 4;
    vdelay = 20;
    do_start();
    for (int i = 0; i < 2049; i++) send(2'd1, 8'(i * 7), i == 2048);
    wait_done(300, "t4");
    end_checks("t4", 2'b10);
    chk("t4_sk_writes", 64'(n_wr[1]), 64'd2048);
    chk("t4_drops", 64'(drops), 64'd1);
    seed = 5;
    vdelay = 20;
    do_start();
    for (int i = 0; i < 100; i++) send(2'(i % 4), 8'(8'h55 + i), 1'b0);
    Reset = 1'b1;
    @(negedge clk);
    rst_vals("t5_rst");
    wr_q.delete();
    Reset = 1'b0;
    @(negedge clk);
    do_start();
    for (int i = 0; i < 4; i++) send(2'd0, 8'(8'hC0 + i), i == 3);
    wait_done(300, "t5");
    end_checks("t5", 2'b00);
    chk("t5_c_writes", 64'(n_wr[0]), 64'd4);
    seed = 6;
    vdelay = 40;
    do_start();
    for (int i = 0; i < 8; i++) send(2'(3 - i % 4), 8'(8'hE0 + i), i == 7);
    t = 0;
    while (Cmd != 2'd3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t6_in_run", {62'd0, Cmd}, 64'd3);
    pulse_start();
    t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t6_in_read", {63'd0, res_valid}, 64'd1);
    pulse_start();
    wait_done(300, "t6");
    repeat (20) @(negedge clk);
    end_checks("t6", 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
